rnd_harvester: RTL and testbench

- Downstream consumer of the 48-way free-running random bank.
- Drives the bank's freeze and address inputs, samples one 16-bit raw word per period and runs a serial von Neumann debiaser on it.
- Packs the unbiased bits into bytes, buffers them in a small FIFO and exposes them on a valid/ready byte stream.
- A sticky repetition-count health alarm blocks output when the bank appears stuck.

---
 rtl/snpu_pkg.sv | 28 ++
 rtl/rnd_byte_fifo.sv | 72 +++++++
 rtl/rnd_harvester.sv | 191 +++++++++++++++++++
 tb/tb_rnd_harvester.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/snpu_pkg.sv
// ----------------------------------------------------------------------------
// snpu_pkg
// Shared types and constants for the random-bank harvester:
//   RND_W    - width of one raw word delivered by the bank
//   PAIRS    - bit pairs examined per raw word by the von Neumann debiaser
//   BYTE_W   - width of one output byte
//   harvest_state_e - sampling FSM states
//   vn_keep()       - von Neumann pair test (unequal pair yields a bit)
// ----------------------------------------------------------------------------
package snpu_pkg;

  localparam int RND_W  = 16;
  localparam int PAIRS  = 8;
  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SETTLE  = 2'd1,
    CAPTURE = 2'd2,
    EXTRACT = 2'd3
  } harvest_state_e;

  // A pair carries an unbiased bit only when its two halves differ.
  function automatic logic vn_keep(input logic [1:0] pair);
    return pair[1] ^ pair[0];
  endfunction

endpackage

// File: rtl/rnd_byte_fifo.sv
// ----------------------------------------------------------------------------
// rnd_byte_fifo
// First-word-fall-through FIFO for the harvested bytes. DEPTH must be a power
// of two (>= 2) so the pointers wrap naturally.
// Ports:
//   i_clk, i_rst      clock, asynchronous active-high reset
//   i_push, i_push_data  write strobe/data (ignored when full)
//   i_pop             read strobe (ignored when empty)
//   o_data            head entry, valid whenever o_valid is high
//   o_valid           FIFO non-empty
//   o_full            FIFO full
//   o_level           current occupancy
// ----------------------------------------------------------------------------
module rnd_byte_fifo
  import snpu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = BYTE_W,
  localparam int AW   = $clog2(DEPTH),
  localparam int LW   = AW + 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  output logic             o_full,
  output logic [LW-1:0]    o_level
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_level == LW'(DEPTH));
  assign o_valid   = (r_level != LW'(0));
  assign o_data    = r_mem[r_rd_ptr];
  assign o_level   = r_level;
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && o_valid;

  // Storage, pointers and occupancy; push+pop together leaves level unchanged.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= WIDTH'(0);
      end
      r_wr_ptr <= AW'(0);
      r_rd_ptr <= AW'(0);
      r_level  <= LW'(0);
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_push_data;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/rnd_harvester.sv
// ----------------------------------------------------------------------------
// rnd_harvester
// Samples the free-running random bank once per period (run, freeze/settle,
// capture, extract), debiases each 16-bit word with a serial von Neumann
// extractor, packs the bits into bytes and streams them out of a FWFT FIFO.
// A sticky repetition-count alarm stops sampling when the bank looks stuck.
// Ports:
//   i_clk, i_rst      clock, asynchronous active-high reset
//   i_en              harvesting enable
//   o_bank_freeze     bank freeze (high in SETTLE and CAPTURE)
//   o_bank_addr       bank generator select, advances per capture
//   i_bank_data       raw word from the selected generator
//   o_out_data        FIFO head byte
//   o_out_valid       FIFO non-empty
//   i_out_ready       consumer accepts the head byte
//   o_fifo_level      FIFO occupancy
//   o_alarm           sticky health failure
// ----------------------------------------------------------------------------
module rnd_harvester
  import snpu_pkg::*;
#(
  parameter int RND_N         = 48,
  parameter int ADDR_W        = $clog2(RND_N),
  parameter int RUN_CYCLES    = 16,
  parameter int SETTLE_CYCLES = 2,
  parameter int FIFO_DEPTH    = 4,
  parameter int REP_LIMIT     = 4
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_en,
  output logic                        o_bank_freeze,
  output logic [ADDR_W-1:0]           o_bank_addr,
  input  logic [RND_W-1:0]            i_bank_data,
  output logic [BYTE_W-1:0]           o_out_data,
  output logic                        o_out_valid,
  input  logic                        i_out_ready,
  output logic [$clog2(FIFO_DEPTH):0] o_fifo_level,
  output logic                        o_alarm
);

  // One counter serves all timed states, so size it for the longest one.
  localparam int CNT_W   = $clog2(RUN_CYCLES + SETTLE_CYCLES + PAIRS) + 1;
  localparam int PAIR_AW = $clog2(PAIRS);
  localparam int BCW     = $clog2(BYTE_W);
  localparam int REP_W   = $clog2(REP_LIMIT) + 1;

  harvest_state_e     r_state;
  harvest_state_e     w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               r_freeze;
  logic [ADDR_W-1:0]  r_addr;
  logic [RND_W-1:0]   r_word;
  logic               r_prev_valid;
  logic [REP_W-1:0]   r_rep_cnt;
  logic               r_alarm;
  logic [BYTE_W-1:0]  r_acc;
  logic [BCW-1:0]     r_bitcnt;

  logic               w_fifo_full;
  logic               w_run_ok;
  logic [1:0]         w_pair;
  logic               w_keep;
  logic [BYTE_W-1:0]  w_shift;
  logic               w_push;
  logic               w_same;
  logic [REP_W-1:0]   w_rep_nxt;

  assign w_run_ok = i_en && !w_fifo_full && !r_alarm;

  // Pair k of the captured word is selected by the low counter bits in EXTRACT.
  assign w_pair  = r_word[{r_cnt[PAIR_AW-1:0], 1'b0} +: 2];
  assign w_keep  = (r_state == EXTRACT) && vn_keep(w_pair);
  assign w_shift = {w_pair[1], r_acc[BYTE_W-1:1]};
  // The eighth kept bit completes a byte; the alarm suppresses the push.
  assign w_push  = w_keep && (r_bitcnt == BCW'(BYTE_W - 1)) && !r_alarm;

  // The stored word doubles as the previous capture for the repetition test.
  assign w_same    = r_prev_valid && (i_bank_data == r_word);
  assign w_rep_nxt = w_same ? (r_rep_cnt + REP_W'(1)) : REP_W'(1);

  assign o_bank_freeze = r_freeze;
  assign o_bank_addr   = r_addr;
  assign o_alarm       = r_alarm;

  // Next-state and timing counter for the sampling FSM.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      RUN: begin
        if (w_run_ok) begin
          if (r_cnt == CNT_W'(RUN_CYCLES - 1)) begin
            w_cnt_nxt   = CNT_W'(0);
            w_state_nxt = SETTLE;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end else begin
          w_cnt_nxt = r_cnt;
        end
      end
      SETTLE: begin
        if (r_cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
          w_cnt_nxt   = CNT_W'(0);
          w_state_nxt = CAPTURE;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      CAPTURE: begin
        w_cnt_nxt   = CNT_W'(0);
        w_state_nxt = EXTRACT;
      end
      EXTRACT: begin
        if (r_cnt == CNT_W'(PAIRS - 1)) begin
          w_cnt_nxt   = CNT_W'(0);
          w_state_nxt = RUN;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_cnt_nxt   = CNT_W'(0);
        w_state_nxt = RUN;
      end
    endcase
  end

  // State register; freeze is registered from the next state so it is a
  // glitch-free decode of SETTLE/CAPTURE.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= RUN;
      r_cnt    <= CNT_W'(0);
      r_freeze <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_freeze <= (w_state_nxt == SETTLE) || (w_state_nxt == CAPTURE);
    end
  end

  // Capture, address advance and repetition-count health test.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_word       <= RND_W'(0);
      r_addr       <= ADDR_W'(0);
      r_prev_valid <= 1'b0;
      r_rep_cnt    <= REP_W'(0);
      r_alarm      <= 1'b0;
    end else if (r_state == CAPTURE) begin
      r_word       <= i_bank_data;
      r_addr       <= (r_addr == ADDR_W'(RND_N - 1)) ? ADDR_W'(0) : (r_addr + ADDR_W'(1));
      r_prev_valid <= 1'b1;
      r_rep_cnt    <= w_rep_nxt;
      if (w_rep_nxt >= REP_W'(REP_LIMIT)) begin
        r_alarm <= 1'b1;
      end
    end
  end

  // Debiaser accumulator: kept bits shift in at the MSB, so the first bit of
  // a byte ends up in bit 0.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_acc    <= BYTE_W'(0);
      r_bitcnt <= BCW'(0);
    end else if (w_keep) begin
      r_acc    <= w_shift;
      r_bitcnt <= (r_bitcnt == BCW'(BYTE_W - 1)) ? BCW'(0) : (r_bitcnt + BCW'(1));
    end
  end

  rnd_byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (BYTE_W)
  ) u_fifo (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_push      (w_push),
    .i_push_data (w_shift),
    .i_pop       (i_out_ready),
    .o_data      (o_out_data),
    .o_valid     (o_out_valid),
    .o_full      (w_fifo_full),
    .o_level     (o_fifo_level)
  );

endmodule

// File: tb/tb_rnd_harvester.sv
module tb_rnd_harvester;

  logic        clk;
  logic        rst;
  logic        en;
  logic        bank_freeze;
  logic [5:0]  bank_addr;
  logic [15:0] bank_data;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  fifo_level;
  logic        alarm;

  int n_cmp = 0;
  int n_err = 0;

  // bench-side reference model
  logic [7:0]  exp_q[$];
  logic [7:0]  m_acc;
  int          m_bits;
  logic [15:0] m_prev;
  bit          m_pv;
  int          m_rep;
  bit          m_alarm;
  int          m_addr;

  rnd_harvester dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_en          (en),
    .o_bank_freeze (bank_freeze),
    .o_bank_addr   (bank_addr),
    .i_bank_data   (bank_data),
    .o_out_data    (out_data),
    .o_out_valid   (out_valid),
    .i_out_ready   (out_ready),
    .o_fifo_level  (fifo_level),
    .o_alarm       (alarm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_acc   = 8'h00;
    m_bits  = 0;
    m_prev  = 16'h0000;
    m_pv    = 1'b0;
    m_rep   = 0;
    m_alarm = 1'b0;
    m_addr  = 0;
  endtask

  task automatic model_word(input logic [15:0] w);
    logic [1:0] p;
    if (m_pv && (w == m_prev)) m_rep++;
    else m_rep = 1;
    m_pv   = 1'b1;
    m_prev = w;
    if (m_rep >= 4) m_alarm = 1'b1;
    m_addr = (m_addr == 47) ? 0 : m_addr + 1;
    for (int k = 0; k < 8; k++) begin
      p = w[2*k +: 2];
      if (p == 2'b01 || p == 2'b10) begin
        m_acc = {p[1], m_acc[7:1]};
        m_bits++;
        if (m_bits == 8) begin
          m_bits = 0;
          if (!m_alarm) exp_q.push_back(m_acc);
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_frz(input logic v, output int n);
    n = 0;
    while (bank_freeze !== v && n < 400) begin
      step();
      n++;
    end
    if (bank_freeze !== v) chk("frz_wait", {31'd0, bank_freeze}, {31'd0, v});
  endtask

  // Present garbage outside the capture window and the real word once freeze rises.
  task automatic feed(input logic [15:0] w, input bit chk_lo);
    int lo;
    int hi;
    bank_data = 16'($urandom);
    wait_frz(1'b1, lo);
    bank_data = w;
    model_word(w);
    wait_frz(1'b0, hi);
    bank_data = 16'($urandom);
    chk("frz_hi", hi, 32'd3);
    if (chk_lo) chk("frz_period", lo + hi, 32'd27);
    chk("addr", {26'd0, bank_addr}, m_addr);
  endtask

  task automatic idle_watch(input int n, output int hi_seen);
    hi_seen = 0;
    for (int i = 0; i < n; i++) begin
      step();
      if (bank_freeze !== 1'b0) hi_seen++;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 600) begin
      step();
      n++;
    end
    chk("drain", exp_q.size(), 32'd0);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_frz"},   {31'd0, bank_freeze}, 32'd0);
    chk({tag, "_addr"},  {26'd0, bank_addr},   32'd0);
    chk({tag, "_valid"}, {31'd0, out_valid},   32'd0);
    chk({tag, "_data"},  {24'd0, out_data},    32'd0);
    chk({tag, "_level"}, {29'd0, fifo_level},  32'd0);
    chk({tag, "_alarm"}, {31'd0, alarm},       32'd0);
  endtask

  // Scoreboard consumer: every accepted byte is matched against the model queue.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("byte_unexpected", exp_q.size(), 32'd1);
      else chk("byte", {24'd0, out_data}, {24'd0, exp_q.pop_front()});
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi;
    model_reset();
    rst = 1'b1;
    en = 1'b0;
    out_ready = 1'b1;
    bank_data = 16'h0000;
    repeat (3) step();
    rst = 1'b0;
    step();
    chk_reset_outs("rst");

    // idle with en low
    idle_watch(100, hi);
    chk("idle_frz", hi, 32'd0);
    chk("idle_addr", {26'd0, bank_addr}, 32'd0);
    chk("idle_valid", {31'd0, out_valid}, 32'd0);
    chk("idle_alarm", {31'd0, alarm}, 32'd0);

    // AA/55 stream
    en = 1'b1;
    for (int i = 0; i < 8; i++) feed((i % 2 == 0) ? 16'h9999 : 16'h6666, i != 0);
    en = 1'b0;
    drain();

    // 2 bits per capture -> 0x66 every 4 captures; also sweeps the address wrap
    en = 1'b1;
    for (int i = 0; i < 48; i++) feed((i % 2 == 0) ? 16'h0009 : 16'h0006, i != 0);
    en = 1'b0;
    drain();

    // backpressure: FIFO fills and sampling parks
    out_ready = 1'b0;
    en = 1'b1;
    for (int i = 0; i < 4; i++) feed((i % 2 == 0) ? 16'h9999 : 16'h6666, i != 0);
    idle_watch(40, hi);
    chk("park_frz", hi, 32'd0);
    chk("full_level", {29'd0, fifo_level}, 32'd4);
    chk("full_valid", {31'd0, out_valid}, 32'd1);
    chk("full_head", {24'd0, out_data}, {24'd0, exp_q[0]});
    out_ready = 1'b1;
    feed(16'h9999, 1'b0);
    feed(16'h6666, 1'b1);
    en = 1'b0;
    drain();

    // stuck bank: alarm on the 4th identical capture
    en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      feed(16'h9999, i != 0);
      if (i == 2) chk("alarm_early", {31'd0, alarm}, 32'd0);
    end
    chk("alarm_set", {31'd0, alarm}, 32'd1);
    idle_watch(100, hi);
    chk("alarm_park", hi, 32'd0);
    drain();
    chk("alarm_level", {29'd0, fifo_level}, 32'd0);
    chk("alarm_sticky", {31'd0, alarm}, 32'd1);

    // reset clears alarm; then reset mid-EXTRACT discards FIFO and partial byte
    rst = 1'b1;
    step();
    rst = 1'b0;
    model_reset();
    step();
    chk("rst2_alarm", {31'd0, alarm}, 32'd0);
    out_ready = 1'b0;
    feed(16'h9999, 1'b0);
    feed(16'h0009, 1'b1);
    step();
    step();
    step();
    rst = 1'b1;
    #1;
    chk_reset_outs("rst_mid");
    model_reset();
    en = 1'b0;
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    step();
    en = 1'b1;
    for (int i = 0; i < 4; i++) feed((i % 2 == 0) ? 16'h0006 : 16'h0009, i != 0);
    en = 1'b0;
    drain();
    idle_watch(10, hi);
    chk("end_valid", {31'd0, out_valid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
